// File: rtl/unified_mem_responder_pkg.sv
// Shared types for the unified memory responder: FSM states, access kinds,
// grant owners and the fixed-priority-with-alternation grant rule.
package unified_mem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_IREAD  = 2'd0,
        K_DREAD  = 2'd1,
        K_DWRITE = 2'd2
    } kind_t;

    typedef enum logic {
        G_INST = 1'b0,
        G_DATA = 1'b1
    } grant_t;

    // Wait-state counter width; holds LATENCY-1 for LATENCY up to 15.
    localparam int CNT_W = 4;

    // Data wins unless it also won last time while fetch was waiting.
    function automatic grant_t pick_grant(input logic data_req, input logic inst_req,
                                          input grant_t last);
        if (data_req && inst_req) begin
            return (last == G_DATA) ? G_INST : G_DATA;
        end
        return data_req ? G_DATA : G_INST;
    endfunction

endpackage

// File: rtl/unified_mem_responder_mem_array.sv
// Single-port synchronous word RAM.
module unified_mem_responder_mem_array #(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // One access per enabled edge; reads update dout, writes leave it alone.
    // NOTE: the array has no reset branch on purpose -- a reset loop over every
    // word would stop this mapping onto block RAM, and contents must survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Memory-side responder shared by the CPU's fetch and data ports. One access
// is in flight at a time; each completes LATENCY cycles after acceptance with
// a one-cycle ack on the port that issued it.
module unified_mem_responder
    import unified_mem_responder_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_ack,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_ack,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    kind_t              kind_q;
    grant_t             last_grant;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        inst_hold;
    logic [31:0]        mem_hold;
    logic               inst_ack_q;
    logic               mem_ack_q;

    logic               data_req;
    logic               inst_req;
    logic               accept;
    logic               fire;
    grant_t             grant;
    kind_t              new_kind;
    logic [ADDR_W-1:0]  new_idx;

    logic               ram_en;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [31:0]        ram_din;
    logic [31:0]        ram_dout;

    // Byte-offset and alias bits above the array depth are dropped by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign data_req = mem_ren | mem_wen;
    assign inst_req = inst_ren;
    assign accept   = (state == S_IDLE) && (data_req || inst_req);

    // Decide the owner, kind and word index of a request offered this cycle.
    // NOTE: every output gets a default before the if, so no latch can be inferred.
    always_comb begin
        grant    = pick_grant(data_req, inst_req, last_grant);
        new_kind = K_IREAD;
        new_idx  = inst_addr[ADDR_W+1:2];
        if (grant == G_DATA) begin
            new_kind = mem_wen ? K_DWRITE : K_DREAD;
            new_idx  = mem_addr[ADDR_W+1:2];
        end
    end

    // The array is touched on the last wait-state edge; with LATENCY=1 that is
    // the acceptance edge itself, so the live request feeds the array directly.
    assign fire     = (accept && (CNT_LOAD == '0)) || ((state == S_BUSY) && (cnt == CNT_ONE));
    assign ram_addr = accept ? new_idx : idx_q;
    assign ram_din  = accept ? mem_dout : wdata_q;
    assign ram_we   = fire && ((accept ? new_kind : kind_q) == K_DWRITE);
    // Held reset must not let a LATENCY=1 write slip into the array.
    assign ram_en   = fire && rst_n;

    unified_mem_responder_mem_array #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Access sequencer: accept, count wait states, respond for one cycle.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_grant <= G_INST;
            kind_q     <= K_IREAD;
            idx_q      <= '0;
            wdata_q    <= '0;
            inst_ack_q <= 1'b0;
            mem_ack_q  <= 1'b0;
            inst_hold  <= '0;
            mem_hold   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        kind_q     <= new_kind;
                        idx_q      <= new_idx;
                        wdata_q    <= mem_dout;
                        last_grant <= grant;
                        cnt        <= CNT_LOAD;
                        if (fire) begin
                            state      <= S_RESP;
                            inst_ack_q <= (new_kind == K_IREAD);
                            mem_ack_q  <= (new_kind != K_IREAD);
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (fire) begin
                        state      <= S_RESP;
                        inst_ack_q <= (kind_q == K_IREAD);
                        mem_ack_q  <= (kind_q != K_IREAD);
                    end
                end
                S_RESP: begin
                    // Requests seen here are the ones being retired; never sampled.
                    state      <= S_IDLE;
                    inst_ack_q <= 1'b0;
                    mem_ack_q  <= 1'b0;
                    if (kind_q == K_IREAD) begin
                        inst_hold <= ram_dout;
                    end else if (kind_q == K_DREAD) begin
                        mem_hold <= ram_dout;
                    end else begin
                        mem_hold <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The RAM output register carries read data during the ack cycle; the
    // hold registers keep each port's last value afterwards.
    assign inst_ack  = inst_ack_q;
    assign mem_ack   = mem_ack_q;
    assign inst_data = inst_ack_q ? ram_dout : inst_hold;
    assign mem_din   = mem_ack_q ? ((kind_q == K_DWRITE) ? 32'h0 : ram_dout) : mem_hold;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 2, 4) each driven by
// directed and random requests and compared every cycle against a
// transaction-level model of the port protocol.
module tb_unified_mem_responder;

    localparam int AW         = 10;
    localparam int RAND_CYC   = 300;
    localparam int TIME_LIMIT = 400000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit done [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[11:2] = 10'($urandom_range(0, 31));
        return a;
    endfunction

    function automatic logic [31:0] pre_val(input int i);
        return (i == 0) ? 32'h2008_0005 : (32'hC0DE_0000 | 32'(i));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        logic        rst_n     = 1'b0;
        logic        inst_ren  = 1'b0;
        logic        mem_ren   = 1'b0;
        logic        mem_wen   = 1'b0;
        logic [31:0] inst_addr = '0;
        logic [31:0] mem_addr  = '0;
        logic [31:0] mem_dout  = '0;
        logic [31:0] inst_data;
        logic [31:0] mem_din;
        logic        inst_ack;
        logic        mem_ack;
        logic        busy;

        unified_mem_responder #(
            .ADDR_W    (AW),
            .LATENCY   (LAT),
            .INIT_FILE ("")
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .inst_ren  (inst_ren),
            .inst_addr (inst_addr),
            .inst_data (inst_data),
            .inst_ack  (inst_ack),
            .mem_ren   (mem_ren),
            .mem_wen   (mem_wen),
            .mem_addr  (mem_addr),
            .mem_dout  (mem_dout),
            .mem_din   (mem_din),
            .mem_ack   (mem_ack),
            .busy      (busy)
        );

        // Transaction model: a request accepted at the edge ending cycle c is
        // answered in cycle c+LAT, the responder is free again from c+LAT+1,
        // and the array effect lands on the edge just before the answer.
        logic [31:0]   mmem [1<<AW];
        int            cyc        = 0;
        int            free_at    = 0;
        int            ack_cyc    = 0;
        bit            pend       = 0;
        bit            pend_inst  = 0;
        bit            pend_write = 0;
        bit            last_data  = 0;
        logic [AW-1:0] p_idx      = '0;
        logic [31:0]   p_wdata    = '0;
        logic [31:0]   p_rdata    = '0;
        logic [31:0]   inst_hold  = '0;
        logic [31:0]   mem_hold   = '0;

        always @(posedge clk or negedge rst_n) begin
            bit d;
            if (!rst_n) begin
                pend      = 0;
                free_at   = 0;
                last_data = 0;
                inst_hold = '0;
                mem_hold  = '0;
            end else begin
                if (pend && cyc == ack_cyc) begin
                    if (pend_inst) inst_hold = p_rdata;
                    else           mem_hold  = pend_write ? 32'h0 : p_rdata;
                    pend = 0;
                end
                if (cyc >= free_at && (inst_ren || mem_ren || mem_wen)) begin
                    d          = (mem_ren || mem_wen) && (!inst_ren || !last_data);
                    last_data  = d;
                    pend       = 1;
                    pend_inst  = !d;
                    pend_write = d && mem_wen;
                    p_idx      = d ? mem_addr[AW+1:2] : inst_addr[AW+1:2];
                    p_wdata    = mem_dout;
                    ack_cyc    = cyc + LAT;
                    free_at    = cyc + LAT + 1;
                end
                if (pend && cyc == ack_cyc - 1) begin
                    if (pend_write) mmem[p_idx] = p_wdata;
                    else            p_rdata     = mmem[p_idx];
                end
                cyc++;
            end
        end

        always @(negedge clk) begin
            bit          ea_i;
            bit          ea_m;
            logic [31:0] ed_i;
            logic [31:0] ed_m;
            ea_i = pend && (cyc == ack_cyc) && pend_inst;
            ea_m = pend && (cyc == ack_cyc) && !pend_inst;
            ed_i = ea_i ? p_rdata : inst_hold;
            ed_m = ea_m ? (pend_write ? 32'h0 : p_rdata) : mem_hold;
            check($sformatf("L%0d busy/acks", LAT), {61'd0, busy, inst_ack, mem_ack},
                  {61'd0, (cyc < free_at), ea_i, ea_m});
            check($sformatf("L%0d inst_data/mem_din", LAT), {inst_data, mem_din}, {ed_i, ed_m});
        end

        // Issue one request, wait (bounded) for its ack, then withdraw it.
        task automatic access(input bit is_inst, input bit ren, input bit wen,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int lat, output int at);
            if (is_inst) begin
                inst_ren  = 1'b1;
                inst_addr = addr;
            end else begin
                mem_ren  = ren;
                mem_wen  = wen;
                mem_addr = addr;
                mem_dout = wdata;
            end
            lat   = -1;
            at    = -1;
            rdata = 'x;
            for (int n = 0; n < 64; n++) begin
                @(negedge clk);
                if (is_inst ? inst_ack : mem_ack) begin
                    rdata = is_inst ? inst_data : mem_din;
                    lat   = n;
                    at    = cyc;
                    break;
                end
            end
            @(posedge clk);
            #1;
            inst_ren = 1'b0;
            mem_ren  = 1'b0;
            mem_wen  = 1'b0;
        endtask

        initial begin
            logic [31:0] rd;
            int          lat;
            int          at;
            int          prev;
            int          nack;
            logic [3:0]  order;
            logic [31:0] exp_fetch [3];

            // Reset state.
            @(negedge clk);
            check($sformatf("L%0d reset ctl", LAT), {61'd0, busy, inst_ack, mem_ack}, 64'd0);
            check($sformatf("L%0d reset data", LAT), {inst_data, mem_din}, 64'd0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;

            // Preload the working set of words through the data port.
            for (int i = 0; i < 32; i++) begin
                access(1'b0, 1'b0, 1'b1, 32'(i) << 2, pre_val(i), rd, lat, at);
                check($sformatf("L%0d preload latency", LAT), 64'(lat), 64'(LAT));
                check($sformatf("L%0d preload din", LAT), {32'd0, rd}, 64'd0);
            end

            // Single fetch of word 0.
            access(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rd, lat, at);
            check($sformatf("L%0d fetch latency", LAT), 64'(lat), 64'(LAT));
            check($sformatf("L%0d fetch data", LAT), {32'd0, rd}, {32'd0, 32'h2008_0005});

            // Contention: both ports held, grants alternate starting with data.
            inst_addr = 32'h0;
            mem_addr  = 32'h40;
            inst_ren  = 1'b1;
            mem_ren   = 1'b1;
            nack      = 0;
            prev      = 0;
            order     = '0;
            for (int n = 0; n < 64 && nack < 4; n++) begin
                @(negedge clk);
                if (inst_ack || mem_ack) begin
                    order = {order[2:0], mem_ack};
                    if (nack > 0) begin
                        check($sformatf("L%0d contention spacing", LAT), 64'(cyc - prev), 64'(LAT + 1));
                    end
                    prev = cyc;
                    nack++;
                end
            end
            @(posedge clk);
            #1;
            inst_ren = 1'b0;
            mem_ren  = 1'b0;
            check($sformatf("L%0d contention order", LAT), {60'd0, order}, {60'd0, 4'b1010});

            // Write then read back, directly and through an alias address.
            access(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, rd, lat, at);
            check($sformatf("L%0d write din", LAT), {32'd0, rd}, 64'd0);
            access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, rd, lat, at);
            check($sformatf("L%0d read 0x40", LAT), {32'd0, rd}, {32'd0, 32'hDEAD_BEEF});
            access(1'b0, 1'b1, 1'b0, 32'h1040, 32'h0, rd, lat, at);
            check($sformatf("L%0d read alias 0x1040", LAT), {32'd0, rd}, {32'd0, 32'hDEAD_BEEF});

            // Read and write both asserted behaves as a write.
            access(1'b0, 1'b1, 1'b1, 32'h8, 32'h1234_5678, rd, lat, at);
            check($sformatf("L%0d rw-both din", LAT), {32'd0, rd}, 64'd0);
            access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, rd, lat, at);
            check($sformatf("L%0d read 0x8", LAT), {32'd0, rd}, {32'd0, 32'h1234_5678});

            // Back-to-back fetches, each issued right after the previous ack.
            exp_fetch[0] = 32'h2008_0005;
            exp_fetch[1] = 32'hC0DE_0001;
            exp_fetch[2] = 32'h1234_5678;
            for (int i = 0; i < 3; i++) begin
                access(1'b1, 1'b0, 1'b0, 32'(i) << 2, 32'h0, rd, lat, at);
                check($sformatf("L%0d b2b fetch %0d", LAT, i), {32'd0, rd}, {32'd0, exp_fetch[i]});
                if (i > 0) begin
                    check($sformatf("L%0d b2b spacing", LAT), 64'(at - prev), 64'(LAT + 1));
                end
                prev = at;
            end

            // Reset one cycle into a write: only a LATENCY=1 write has landed.
            access(1'b0, 1'b0, 1'b1, 32'h10, 32'hAAAA_AAAA, rd, lat, at);
            mem_addr = 32'h10;
            mem_dout = 32'hFFFF_FFFF;
            mem_wen  = 1'b1;
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            check($sformatf("L%0d mid-reset ctl", LAT), {61'd0, busy, inst_ack, mem_ack}, 64'd0);
            repeat (2) @(posedge clk);
            #1;
            mem_wen = 1'b0;
            rst_n   = 1'b1;
            access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, rd, lat, at);
            check($sformatf("L%0d read after reset", LAT), {32'd0, rd},
                  {32'd0, (LAT == 1) ? 32'hFFFF_FFFF : 32'hAAAA_AAAA});

            // Random traffic from two independent requesters.
            fork
                begin
                    for (int ci = 0; ci < RAND_CYC; ci++) begin
                        logic got_i;
                        @(negedge clk);
                        got_i = inst_ack;
                        @(posedge clk);
                        #1;
                        if (inst_ren && (got_i || $urandom_range(0, 24) == 0)) inst_ren = 1'b0;
                        if (!inst_ren && $urandom_range(0, 2) == 0) begin
                            inst_ren  = 1'b1;
                            inst_addr = rand_addr();
                        end
                    end
                    inst_ren = 1'b0;
                end
                begin
                    for (int cd = 0; cd < RAND_CYC; cd++) begin
                        logic got_m;
                        int   k;
                        @(negedge clk);
                        got_m = mem_ack;
                        @(posedge clk);
                        #1;
                        if ((mem_ren || mem_wen) && (got_m || $urandom_range(0, 24) == 0)) begin
                            mem_ren = 1'b0;
                            mem_wen = 1'b0;
                        end
                        if (!(mem_ren || mem_wen) && $urandom_range(0, 2) == 0) begin
                            k        = $urandom_range(0, 3);
                            mem_ren  = (k != 2);
                            mem_wen  = (k >= 2);
                            mem_addr = rand_addr();
                            mem_dout = $urandom;
                        end
                    end
                    mem_ren = 1'b0;
                    mem_wen = 1'b0;
                end
            join
            repeat (2 * LAT + 4) @(posedge clk);
            done[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done[0] && done[1] && done[2]);
            #(TIME_LIMIT);
        join_any
        check("all lanes finished", {61'd0, done[0], done[1], done[2]}, {61'd0, 3'b111});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
